match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_pkg.sv | 40 ++++
 rtl/frame_timer.sv | 31 +++
 rtl/match_controller.sv | 151 +++++++++++++++
 tb/tb_match_controller.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Shared types and default timing for the two-player match controller.
package match_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_COUNTDOWN = 3'd1,
      ST_PLAY      = 3'd2,
      ST_KO        = 3'd3,
      ST_GAME_OVER = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'd0,
      WIN_P1   = 2'd1,
      WIN_P2   = 2'd2,
      WIN_DRAW = 2'd3
   } winner_e;

   localparam int unsigned DEF_STOCKS       = 3;
   localparam int unsigned DEF_COUNT_FRAMES = 60;
   localparam int unsigned DEF_KO_FRAMES    = 90;
   localparam int unsigned DEF_BLAST_X_MAX  = 630;
   localparam int unsigned DEF_BLAST_Y_MAX  = 470;
   localparam int unsigned POS_W            = 10;
   localparam int unsigned STOCK_W          = 2;

   function automatic logic [STOCK_W-1:0] stock_dec(input logic [STOCK_W-1:0] s);
      return (s == '0) ? '0 : s - STOCK_W'(1);
   endfunction

   // A player with no stocks left loses; both empty is a draw.
   function automatic winner_e pick_winner(input logic [STOCK_W-1:0] s1,
                                           input logic [STOCK_W-1:0] s2);
      if (s1 == '0 && s2 == '0) return WIN_DRAW;
      if (s2 == '0)             return WIN_P1;
      if (s1 == '0)             return WIN_P2;
      return WIN_NONE;
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable frame down-counter; done_c_o flags the tick that brings it to zero.
module frame_timer #(
   parameter int unsigned W = 8
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         tick_i,
   output logic         done_c_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (tick_i && cnt_q != '0) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   assign done_c_o = tick_i && (cnt_q == W'(1));

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/match_controller.sv
// Match sequencing: countdown, play, KO pause and game over with stock tracking.
module match_controller
   import match_pkg::*;
#(
   parameter int unsigned STOCKS       = DEF_STOCKS,
   parameter int unsigned COUNT_FRAMES = DEF_COUNT_FRAMES,
   parameter int unsigned KO_FRAMES    = DEF_KO_FRAMES,
   parameter int unsigned BLAST_X_MAX  = DEF_BLAST_X_MAX,
   parameter int unsigned BLAST_Y_MAX  = DEF_BLAST_Y_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_tick,
   input  logic             start,
   input  logic [POS_W-1:0] p1_x,
   input  logic [POS_W-1:0] p1_y,
   input  logic [POS_W-1:0] p2_x,
   input  logic [POS_W-1:0] p2_y,
   output logic             run_timer,
   output logic             p1_respawn,
   output logic             p2_respawn,
   output logic [1:0]       p1_stocks,
   output logic [1:0]       p2_stocks,
   output logic [1:0]       countdown,
   output logic [1:0]       winner,
   output logic [2:0]       state
);

   localparam int unsigned TMAX = (COUNT_FRAMES > KO_FRAMES) ? COUNT_FRAMES : KO_FRAMES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   state_e              state_q, state_d;
   winner_e             winner_q, winner_d;
   logic [STOCK_W-1:0]  s1_q, s1_d, s2_q, s2_d;
   logic [1:0]          cd_q, cd_d;
   logic [1:0]          ko_q, ko_d;
   logic [1:0]          resp_q, resp_d;
   logic                run_q, run_d;

   logic                tmr_load;
   logic [TW-1:0]       tmr_val;
   logic                tmr_done;
   logic                oob1, oob2;

   assign oob1 = (p1_x > POS_W'(BLAST_X_MAX)) || (p1_y > POS_W'(BLAST_Y_MAX));
   assign oob2 = (p2_x > POS_W'(BLAST_X_MAX)) || (p2_y > POS_W'(BLAST_Y_MAX));

   frame_timer #(.W(TW)) u_timer (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .tick_i     (frame_tick),
      .done_c_o   (tmr_done)
   );

   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      cd_d     = cd_q;
      ko_d     = ko_q;
      resp_d   = '0;
      tmr_load = 1'b0;
      tmr_val  = TW'(COUNT_FRAMES);

      case (state_q)
         ST_IDLE, ST_GAME_OVER: begin
            if (start) begin
               state_d  = ST_COUNTDOWN;
               winner_d = WIN_NONE;
               s1_d     = STOCK_W'(STOCKS);
               s2_d     = STOCK_W'(STOCKS);
               cd_d     = 2'd3;
               resp_d   = 2'b11;
               tmr_load = 1'b1;
               // a tick landing on the start edge already counts for digit 3
               tmr_val  = TW'(COUNT_FRAMES) - TW'(frame_tick);
            end
         end
         ST_COUNTDOWN: begin
            if (tmr_done) begin
               if (cd_q == 2'd1) begin
                  state_d = ST_PLAY;
                  cd_d    = 2'd0;
               end else begin
                  cd_d     = cd_q - 2'd1;
                  tmr_load = 1'b1;
               end
            end
         end
         ST_PLAY: begin
            if (frame_tick && (oob1 || oob2)) begin
               state_d  = ST_KO;
               ko_d     = {oob2, oob1};
               if (oob1) s1_d = stock_dec(s1_q);
               if (oob2) s2_d = stock_dec(s2_q);
               tmr_load = 1'b1;
               tmr_val  = TW'(KO_FRAMES);
            end
         end
         ST_KO: begin
            if (tmr_done) begin
               if (s1_q == '0 || s2_q == '0) begin
                  state_d  = ST_GAME_OVER;
                  winner_d = pick_winner(s1_q, s2_q);
               end else begin
                  state_d = ST_PLAY;
                  resp_d  = ko_q;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      run_d = (state_d == ST_PLAY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         winner_q <= WIN_NONE;
         s1_q     <= '0;
         s2_q     <= '0;
         cd_q     <= '0;
         ko_q     <= '0;
         resp_q   <= '0;
         run_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         cd_q     <= cd_d;
         ko_q     <= ko_d;
         resp_q   <= resp_d;
         run_q    <= run_d;
      end
   end

   assign state      = state_q;
   assign winner     = winner_q;
   assign p1_stocks  = s1_q;
   assign p2_stocks  = s2_q;
   assign countdown  = cd_q;
   assign p1_respawn = resp_q[0];
   assign p2_respawn = resp_q[1];
   assign run_timer  = run_q;

endmodule

// File: tb/tb_match_controller.sv
// Scoreboard bench: a tick-level match model predicts each visible output change.
module tb_match_controller;

   localparam int unsigned NS = 3;
   localparam int unsigned CF = 2;
   localparam int unsigned KF = 3;
   localparam int XMAX = 630;
   localparam int YMAX = 470;

   localparam int PH_IDLE = 0, PH_CD = 1, PH_PLAY = 2, PH_KO = 3, PH_GO = 4;

   typedef logic [13:0] snap_t;

   logic       clk = 1'b0;
   logic       rst, frame_tick, start;
   logic [9:0] p1_x, p1_y, p2_x, p2_y;
   logic       run_timer, p1_respawn, p2_respawn;
   logic [1:0] p1_stocks, p2_stocks, countdown, winner;
   logic [2:0] state;

   always #5 clk = ~clk;

   match_controller #(
      .STOCKS(NS), .COUNT_FRAMES(CF), .KO_FRAMES(KF),
      .BLAST_X_MAX(630), .BLAST_Y_MAX(470)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start),
      .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
      .run_timer(run_timer), .p1_respawn(p1_respawn), .p2_respawn(p2_respawn),
      .p1_stocks(p1_stocks), .p2_stocks(p2_stocks), .countdown(countdown),
      .winner(winner), .state(state)
   );

   snap_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   // Match model: phase, ticks left in the current pause, lives and KO flags.
   int    m_phase = PH_IDLE, m_left = 0, m_digit = 0, m_l1 = 0, m_l2 = 0, m_win = 0;
   bit    m_ko1 = 0, m_ko2 = 0, m_r1 = 0, m_r2 = 0;
   snap_t m_last = '1;

   function automatic snap_t model_snap();
      return {3'(m_phase), 2'(m_digit), 2'(m_l1), 2'(m_l2), 2'(m_win),
              (m_phase == PH_PLAY), m_r1, m_r2};
   endfunction

   task automatic model_step(input bit r, input bit s, input bit t,
                             input int x1, input int y1, input int x2, input int y2);
      bit o1, o2;
      o1 = (x1 > XMAX) || (y1 > YMAX);
      o2 = (x2 > XMAX) || (y2 > YMAX);
      m_r1 = 0;
      m_r2 = 0;
      if (r) begin
         m_phase = PH_IDLE; m_left = 0; m_digit = 0;
         m_l1 = 0; m_l2 = 0; m_win = 0; m_ko1 = 0; m_ko2 = 0;
      end else begin
         case (m_phase)
            PH_IDLE, PH_GO: if (s) begin
               m_phase = PH_CD; m_l1 = NS; m_l2 = NS; m_win = 0;
               m_r1 = 1; m_r2 = 1; m_digit = 3;
               m_left = CF - (t ? 1 : 0);
            end
            PH_CD: if (t) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_digit == 1) begin
                     m_phase = PH_PLAY; m_digit = 0;
                  end else begin
                     m_digit--; m_left = CF;
                  end
               end
            end
            PH_PLAY: if (t && (o1 || o2)) begin
               if (o1 && m_l1 > 0) m_l1--;
               if (o2 && m_l2 > 0) m_l2--;
               m_ko1 = o1; m_ko2 = o2;
               m_phase = PH_KO; m_left = KF;
            end
            PH_KO: if (t) begin
               m_left--;
               if (m_left == 0) begin
                  if (m_l1 == 0 || m_l2 == 0) begin
                     m_phase = PH_GO;
                     m_win = (m_l1 == 0 && m_l2 == 0) ? 3 : (m_l2 == 0 ? 1 : 2);
                  end else begin
                     m_phase = PH_PLAY; m_r1 = m_ko1; m_r2 = m_ko2;
                  end
               end
            end
            default: m_phase = PH_IDLE;
         endcase
      end
   endtask

   // One clock of stimulus: drive, predict, then wait for the edge.
   task automatic cyc(input bit r, input bit s, input bit t,
                      input int x1 = 100, input int y1 = 100,
                      input int x2 = 100, input int y2 = 100);
      snap_t sn;
      rst = r; start = s; frame_tick = t;
      p1_x = 10'(x1); p1_y = 10'(y1); p2_x = 10'(x2); p2_y = 10'(y2);
      model_step(r, s, t, x1, y1, x2, y2);
      sn = model_snap();
      if (sn != m_last) begin
         exp_q.push_back(sn);
         m_last = sn;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tk(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 1);
         cyc(0, 0, 0);
      end
   endtask

   // Monitor: every visible change of the outputs must match the next prediction.
   initial begin
      snap_t last, obs, e;
      last = '1;
      forever begin
         @(posedge clk);
         #1;
         obs = {state, countdown, p1_stocks, p2_stocks, winner,
                run_timer, p1_respawn, p2_respawn};
         if (obs !== last) begin
            last = obs;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_change t=%0t got=%h need=no_change", $time, obs);
            end else begin
               e = exp_q.pop_front();
               if (obs !== e) begin
                  bad++;
                  $display("FAIL snapshot t=%0t got=%h need=%h", $time, obs, e);
               end
            end
         end
      end
   end

   initial begin
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      // countdown 3,3,2,2,1,1 then play; start during countdown is ignored
      cyc(0, 1, 0);
      cyc(0, 0, 1);
      cyc(0, 1, 0);
      tk(5);
      tk(2);
      // p1 falls below the stage
      cyc(0, 0, 1, 100, 500, 100, 100);
      tk(3);
      // p2 wrapped to a negative x
      cyc(0, 0, 1, 100, 100, 1020, 100);
      tk(3);
      cyc(0, 0, 1, 700, 100, 100, 900);
      tk(3);
      // both on last stock, both out together
      cyc(0, 0, 1, 700, 100, 100, 900);
      tk(3);
      cyc(0, 0, 0);
      cyc(0, 0, 1);
      // restart from game over
      cyc(0, 1, 0);
      tk(6);
      cyc(0, 0, 1, 100, 800, 100, 100);
      tk(1);
      cyc(1, 0, 0);
      cyc(0, 0, 0);
      // start coincident with a tick, then reset mid-countdown
      cyc(0, 1, 1);
      tk(2);
      cyc(1, 0, 0);
      cyc(0, 0, 0);

      for (int i = 0; i < 4000; i++) begin
         bit r, s, t;
         int x1, y1, x2, y2;
         r  = ($urandom_range(0, 299) == 0);
         s  = ($urandom_range(0, 24) == 0);
         t  = ($urandom_range(0, 2) == 0);
         x1 = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 630);
         y1 = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 470);
         x2 = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 630);
         y2 = ($urandom_range(0, 12) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 470);
         cyc(r, s, t, x1, y1, x2, y2);
      end

      for (int i = 0; i < 4; i++) cyc(0, 0, 0);

      while (exp_q.size() != 0) begin
         snap_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL missing_change got=no_change need=%h", e);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
